// File: rtl/ex_if_arith_unit.sv
// Registered arithmetic cluster: IF next-PC adder, EX branch-target adder and EX ALU with zero flag.
// Every output is captured on the rising edge, giving one cycle of latency from operands to results.
module ex_if_arith_unit #(
    parameter int XLEN    = 64,
    parameter int PC_STEP = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_out_aim_in,
    output logic [XLEN-1:0] adder_if_out_mux_if_in,
    input  logic [XLEN-1:0] pcid_exout,
    input  logic [XLEN-1:0] imm_data_exout,
    output logic [XLEN-1:0] adder_ex_out_mem_in,
    input  logic [XLEN-1:0] mux_1_out_alu_in,
    input  logic [XLEN-1:0] mux_ex_out_alu_in,
    input  logic [3:0]      ALUOp,
    output logic [XLEN-1:0] Result,
    output logic            zero
);

    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] if_sum_q, if_sum_d;
    logic [XLEN-1:0] ex_sum_q, ex_sum_d;
    logic [XLEN-1:0] alu_q, alu_d;
    logic            zero_q, zero_d;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] imm_shl;

    // Only the low log2(XLEN) bits of operand B act as a shift amount
    assign shamt   = mux_ex_out_alu_in[SHW-1:0];
    assign imm_shl = imm_data_exout << 1;

    assign if_sum_d = pc_out_aim_in + XLEN'(PC_STEP);
    assign ex_sum_d = pcid_exout + imm_shl;

    always_comb begin
        alu_d = '0;
        unique case (ALUOp)
            4'b0000: alu_d = mux_1_out_alu_in & mux_ex_out_alu_in;
            4'b0001: alu_d = mux_1_out_alu_in | mux_ex_out_alu_in;
            4'b0010: alu_d = mux_1_out_alu_in + mux_ex_out_alu_in;
            4'b0011: alu_d = mux_1_out_alu_in ^ mux_ex_out_alu_in;
            4'b0100: alu_d = mux_1_out_alu_in << shamt;
            4'b0101: alu_d = mux_1_out_alu_in >> shamt;
            4'b0110: alu_d = mux_1_out_alu_in - mux_ex_out_alu_in;
            4'b0111: alu_d = {{(XLEN-1){1'b0}},
                              ($signed(mux_1_out_alu_in) < $signed(mux_ex_out_alu_in))};
            4'b1000: alu_d = $unsigned($signed(mux_1_out_alu_in) >>> shamt);
            4'b1001: alu_d = {{(XLEN-1){1'b0}}, (mux_1_out_alu_in < mux_ex_out_alu_in)};
            4'b1100: alu_d = ~(mux_1_out_alu_in | mux_ex_out_alu_in);
            default: alu_d = '0;
        endcase
    end

    assign zero_d = (alu_d == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            if_sum_q <= '0;
            ex_sum_q <= '0;
            alu_q    <= '0;
            zero_q   <= 1'b1;
        end else begin
            if_sum_q <= if_sum_d;
            ex_sum_q <= ex_sum_d;
            alu_q    <= alu_d;
            zero_q   <= zero_d;
        end
    end

    assign adder_if_out_mux_if_in = if_sum_q;
    assign adder_ex_out_mem_in    = ex_sum_q;
    assign Result                 = alu_q;
    assign zero                   = zero_q;

endmodule

// File: tb/tb_ex_if_arith_unit.sv
// Scoreboard bench for ex_if_arith_unit: expected outputs are queued as operands are driven
// and compared one edge later.
module tb_ex_if_arith_unit;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic [XLEN-1:0] pc_out_aim_in, pcid_exout, imm_data_exout;
    logic [XLEN-1:0] mux_1_out_alu_in, mux_ex_out_alu_in;
    logic [3:0]      ALUOp;
    logic [XLEN-1:0] adder_if_out_mux_if_in, adder_ex_out_mem_in, Result;
    logic            zero;

    typedef struct {
        logic [XLEN-1:0] if_v;
        logic [XLEN-1:0] ex_v;
        logic [XLEN-1:0] res;
        logic            z;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    ex_if_arith_unit #(.XLEN(XLEN), .PC_STEP(4)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .pc_out_aim_in          (pc_out_aim_in),
        .adder_if_out_mux_if_in (adder_if_out_mux_if_in),
        .pcid_exout             (pcid_exout),
        .imm_data_exout         (imm_data_exout),
        .adder_ex_out_mem_in    (adder_ex_out_mem_in),
        .mux_1_out_alu_in       (mux_1_out_alu_in),
        .mux_ex_out_alu_in      (mux_ex_out_alu_in),
        .ALUOp                  (ALUOp),
        .Result                 (Result),
        .zero                   (zero)
    );

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%h, expected 0x%h", tag, obs, exp);
    endtask

    function automatic logic [XLEN-1:0] ref_alu(input logic [3:0] op, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        int sh;
        logic [XLEN-1:0] r;
        sh = int'(b % 64);
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  r = a + b;
            4'd3:  r = a ^ b;
            4'd4:  r = a << sh;
            4'd5:  r = a >> sh;
            4'd6:  r = a + (~b) + 64'd1;
            4'd7:  r = (a[63] != b[63]) ? {63'd0, a[63]} : {63'd0, (a < b)};
            4'd8: begin
                r = a >> sh;
                if (a[63]) for (int i = 0; i < sh; i++) r[63-i] = 1'b1;
            end
            4'd9:  r = {63'd0, (a < b)};
            4'd12: r = ~(a | b);
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic step(input logic rst, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] pcid,
                        input logic [XLEN-1:0] imm, input logic [3:0] op,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input string tag);
        exp_t e, got;
        @(negedge clk);
        reset             = rst;
        pc_out_aim_in     = pc;
        pcid_exout        = pcid;
        imm_data_exout    = imm;
        ALUOp             = op;
        mux_1_out_alu_in  = a;
        mux_ex_out_alu_in = b;
        if (rst) begin
            e.if_v = '0; e.ex_v = '0; e.res = '0; e.z = 1'b1;
        end else begin
            e.if_v = pc + 64'd4;
            e.ex_v = pcid + {imm[62:0], 1'b0};
            e.res  = ref_alu(op, a, b);
            e.z    = (e.res == 64'd0);
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            got = sb_q.pop_front();
            check({tag, "_if"},   adder_if_out_mux_if_in, got.if_v);
            check({tag, "_ex"},   adder_ex_out_mem_in,    got.ex_v);
            check({tag, "_res"},  Result,                 got.res);
            check({tag, "_zero"}, {63'd0, zero},          {63'd0, got.z});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [XLEN-1:0] ra, rb, rpc, rpcid, rimm;
        logic [3:0]      rop;
        reset = 1'b1;
        pc_out_aim_in = '0; pcid_exout = '0; imm_data_exout = '0;
        mux_1_out_alu_in = '0; mux_ex_out_alu_in = '0; ALUOp = '0;

        step(1, 64'h1234, 64'h55, 64'h7, 4'd2, 64'd3, 64'd4, "rst0");
        step(1, 64'hDEAD, 64'hBEEF, 64'h9, 4'd1, 64'hFF, 64'h1, "rst1");
        step(0, 64'h100, 64'h0, 64'h0, 4'd2, 64'd0, 64'd0, "pc100");
        step(0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1000, 64'h10, 4'd2, 64'd5, 64'd7, "wrap_add");
        step(0, 64'h0, 64'h1000, 64'hFFFF_FFFF_FFFF_FFF8, 4'd6, 64'd9, 64'd9, "pc0_neg_sub0");
        step(0, 64'h8, 64'h0, 64'h0, 4'd6, 64'd0, 64'd1, "sub_neg1");
        step(0, 64'h8, 64'h0, 64'h0, 4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, "add_wrap");
        step(0, 64'h8, 64'h0, 64'h0, 4'd0, 64'hF0, 64'h3C, "and");
        step(0, 64'h8, 64'h0, 64'h0, 4'd1, 64'hF0, 64'h3C, "or");
        step(0, 64'h8, 64'h0, 64'h0, 4'd3, 64'hF0, 64'h3C, "xor");
        step(0, 64'h8, 64'h0, 64'h0, 4'd12, 64'hF0, 64'h3C, "nor");
        step(0, 64'h8, 64'h0, 64'h0, 4'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, "slt");
        step(0, 64'h8, 64'h0, 64'h0, 4'd9, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, "sltu");
        step(0, 64'h8, 64'h0, 64'h0, 4'd8, 64'h8000_0000_0000_0000, 64'd4, "sra");
        step(0, 64'h8, 64'h0, 64'h0, 4'd5, 64'h8000_0000_0000_0000, 64'd4, "srl");
        step(0, 64'h8, 64'h0, 64'h0, 4'd4, 64'd1, 64'h41, "sll_mask");
        step(0, 64'h8, 64'h0, 64'h0, 4'd15, 64'hF0, 64'h3C, "undef");

        // Literal spot checks independent of the reference model
        step(0, 64'h0, 64'h1000, 64'h10, 4'd0, 64'hF0, 64'h3C, "lit");
        check("lit_ex", adder_ex_out_mem_in, 64'h1020);
        check("lit_and", Result, 64'h30);
        step(0, 64'h0, 64'h1000, 64'hFFFF_FFFF_FFFF_FFF8, 4'd12, 64'hF0, 64'h3C, "lit2");
        check("lit2_ex", adder_ex_out_mem_in, 64'h0FF0);
        check("lit2_nor", Result, 64'hFFFF_FFFF_FFFF_FF03);

        for (int i = 0; i < 20; i++) begin
            rpc   = {$urandom, $urandom};
            rpcid = {$urandom, $urandom};
            rimm  = {$urandom, $urandom};
            ra    = {$urandom, $urandom};
            rb    = (i % 3 == 0) ? ra : {$urandom, $urandom};
            rop   = 4'($urandom_range(0, 15));
            step((i == 10), rpc, rpcid, rimm, rop, ra, rb, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ex_if_arith_unit.md
Name: ex_if_arith_unit

Overview:
- Registered arithmetic cluster for the five-stage RISC-V pipeline. It merges three functions: the IF-stage next-PC adder (PC+4), the EX-stage branch-target adder (PC + immediate offset), and the EX-stage ALU with zero flag.
- All results are captured in output registers on the rising clock edge, so each result appears one cycle after its operands.
- Feeds the IF next-PC mux, the EX/MEM pipeline register, and the branch AND gate.

Parameters:
- XLEN, 64, datapath width of PC, immediate, ALU operands and result.
- PC_STEP, 4, increment applied by the IF adder.

Ports:
- clk  input  1  pipeline clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- pc_out_aim_in  input  XLEN  current PC from the program counter.
- adder_if_out_mux_if_in  output  XLEN  registered PC + PC_STEP, to the IF next-PC mux.
- pcid_exout  input  XLEN  PC of the instruction in EX.
- imm_data_exout  input  XLEN  sign-extended immediate of the instruction in EX.
- adder_ex_out_mem_in  output  XLEN  registered branch target, to the EX/MEM register.
- mux_1_out_alu_in  input  XLEN  ALU operand A (forwarding mux output).
- mux_ex_out_alu_in  input  XLEN  ALU operand B (ALUSrc mux output).
- ALUOp  input  4  ALU operation select from alu_control_unit.
- Result  output  XLEN  registered ALU result.
- zero  output  1  registered flag, 1 when Result equals 0.

Behaviour:
- Clocking and reset:
  - Single clock domain; no combinational path from any input to any output.
  - At a rising edge with reset=1: adder_if_out_mux_if_in=0, adder_ex_out_mem_in=0, Result=0, zero=1 (consistent with Result=0).
  - Reset has priority over new operands at the same edge.
  - Reset mid-operation discards the in-flight result; the first valid output appears one edge after reset deasserts.
- Latency: every output reflects the inputs sampled at the previous rising edge (1-cycle latency, throughput one result per cycle). Outputs hold between edges.
- IF adder: adder_if_out_mux_if_in <= pc_out_aim_in + PC_STEP, modulo 2^XLEN. 0xFFFF_FFFF_FFFF_FFFC wraps to 0.
- EX adder: adder_ex_out_mem_in <= pcid_exout + (imm_data_exout << 1), modulo 2^XLEN.
  - The immediate is a signed halfword offset; negative immediates yield backward targets.
  - The bit shifted out of the MSB is dropped.
- ALU, with A=mux_1_out_alu_in and B=mux_ex_out_alu_in:
  - 0000 AND: A & B.
  - 0001 OR: A | B.
  - 0010 ADD: A + B, wrap, no overflow flag.
  - 0011 XOR: A ^ B.
  - 0100 SLL: A << B[log2(XLEN)-1:0].
  - 0101 SRL: logical right shift by B[log2(XLEN)-1:0].
  - 0110 SUB: A − B, wrap.
  - 0111 SLT: signed compare; 1 if A<B else 0, zero-extended.
  - 1000 SRA: arithmetic right shift by B[log2(XLEN)-1:0].
  - 1001 SLTU: unsigned compare; 1 if A<B else 0.
  - 1100 NOR: ~(A | B).
  - Any other code: Result <= 0.
  - Shift amounts use only the low log2(XLEN) bits of B; upper bits are ignored.
- zero is registered in the same edge as Result and equals (next Result == 0). It therefore always agrees with the Result it accompanies, including for undefined ALUOp (zero=1).
- The three functions are independent: simultaneous changes on all inputs update all outputs at the same edge without interaction.
- No X-propagation masking is required; outputs are defined whenever inputs are 0/1.

Test Plan:
- Reset: hold reset=1 for 2 edges with arbitrary inputs -> all adder outputs 0, Result=0, zero=1. Deassert with pc_out_aim_in=0x100 -> after next edge adder_if_out_mux_if_in=0x104.
- IF adder wrap: pc_out_aim_in=0xFFFF_FFFF_FFFF_FFFC -> adder_if_out_mux_if_in=0 one edge later. pc_out_aim_in=0x0 -> 0x4.
- EX adder: pcid_exout=0x1000, imm_data_exout=0x10 -> 0x1020. imm_data_exout=−8 (0xFFFF_FFFF_FFFF_FFF8) -> 0x0FF0.
- ALU arithmetic and flag:
  - ADD 5+7 -> Result=12, zero=0.
  - SUB 9−9 -> Result=0, zero=1.
  - SUB 0−1 -> Result=0xFFFF_FFFF_FFFF_FFFF.
  - ADD 0xFFFF_FFFF_FFFF_FFFF+1 -> Result=0, zero=1.
- ALU logic, compare and shifts with A=0xF0, B=0x3C:
  - AND -> 0x30; OR -> 0xFC; XOR -> 0xCC; NOR -> 0xFFFF_FFFF_FFFF_FF03.
  - SLT with A=−1, B=1 -> 1; SLTU with the same operands -> 0.
  - SRA of 0x8000_0000_0000_0000 by 4 -> 0xF800_0000_0000_0000.
  - SLL of 1 by B=0x41 -> 2 (only the low 6 bits of B count).
  - ALUOp=1111 -> Result=0, zero=1.
- Pipelined back-to-back: change all operands every cycle for 20 random cycles -> each output matches a reference model of the previous-cycle inputs. Asserting reset mid-sequence clears the outputs at that edge.
